// File: rtl/tl_phase_sched.sv
// Four-approach traffic-light phase scheduler.
// Round-robin service of vehicle requests, with emergency preemption and
// yellow/all-red clearance between conflicting greens.
module tl_phase_sched #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] emg,
  output logic [2:0] Light_M1,
  output logic [2:0] Light_M2,
  output logic [2:0] Light_M3,
  output logic [2:0] Light_M4,
  output logic [3:0] count,
  output logic [2:0] ps,
  output logic [1:0] grant
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StGreen  = 3'd1,
    StYellow = 3'd2,
    StAllred = 3'd3,
    StEmg    = 3'd4
  } state_e;

  localparam logic [3:0] GreenMinLast = 4'(GREEN_MIN - 1);
  localparam logic [3:0] GreenMaxLast = 4'(GREEN_MAX - 1);
  localparam logic [3:0] YellowLast   = 4'(YELLOW_T - 1);
  localparam logic [3:0] AllredLast   = 4'(ALLRED_T - 1);

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  state_e     r_ps, w_ps_d, w_arb_ps;
  logic [3:0] r_count, w_count_d;
  logic [1:0] r_grant, w_grant_d, w_arb_grant, w_rr_idx;
  logic [2:0] r_light   [4];
  logic [2:0] w_light_d [4];
  logic [3:0] w_grant_oh, w_emg_other, w_req_other;

  assign w_grant_oh  = 4'b0001 << r_grant;
  assign w_emg_other = emg & ~w_grant_oh;
  assign w_req_other = req & ~w_grant_oh;

  // Arbitration: lowest emergency wins, else round-robin from the slot after grant.
  always_comb begin
    w_arb_ps    = StIdle;
    w_arb_grant = r_grant;
    w_rr_idx    = r_grant;
    if (|emg) begin
      w_arb_ps = StEmg;
      // Descending scan so the lowest set index is written last.
      for (int i = 3; i >= 0; i--) begin
        if (emg[i]) w_arb_grant = 2'(i);
      end
    end else if (|req) begin
      w_arb_ps = StGreen;
      // Descending offset scan so the nearest slot after grant wins.
      for (int k = 4; k >= 1; k--) begin
        w_rr_idx = r_grant + 2'(k);
        if (req[w_rr_idx]) w_arb_grant = w_rr_idx;
      end
    end
  end

  // Next-state, next-grant and phase timer.
  always_comb begin
    w_ps_d    = r_ps;
    w_grant_d = r_grant;
    case (r_ps)
      StIdle: begin
        w_ps_d    = w_arb_ps;
        w_grant_d = w_arb_grant;
      end
      StGreen: begin
        if (emg[r_grant]) begin
          w_ps_d = StEmg;
        end else if (|w_emg_other) begin
          w_ps_d = StYellow;
        end else if ((r_count >= GreenMinLast) && (|w_req_other)) begin
          w_ps_d = StYellow;
        end
      end
      StYellow: begin
        if (r_count == YellowLast) w_ps_d = StAllred;
      end
      StAllred: begin
        if (r_count == AllredLast) begin
          w_ps_d    = w_arb_ps;
          w_grant_d = w_arb_grant;
        end
      end
      StEmg: begin
        if (!emg[r_grant]) w_ps_d = StYellow;
      end
      default: w_ps_d = StIdle;
    endcase

    if (w_ps_d != r_ps) begin
      w_count_d = 4'd0;
    end else if ((r_ps == StGreen) && (r_count >= GreenMaxLast)) begin
      // Rest on green: timer parks at the max-green mark.
      w_count_d = GreenMaxLast;
    end else if (r_count != 4'hF) begin
      w_count_d = r_count + 4'd1;
    end else begin
      w_count_d = r_count;
    end
  end

  // Lamp codes derived from the next state so they register alongside it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_light_d[i] = LampRed;
      if (2'(i) == w_grant_d) begin
        if ((w_ps_d == StGreen) || (w_ps_d == StEmg)) begin
          w_light_d[i] = LampGreen;
        end else if (w_ps_d == StYellow) begin
          w_light_d[i] = LampYellow;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ps    <= StIdle;
      r_count <= 4'd0;
      r_grant <= 2'd3;
      for (int i = 0; i < 4; i++) r_light[i] <= LampRed;
    end else begin
      r_ps    <= w_ps_d;
      r_count <= w_count_d;
      r_grant <= w_grant_d;
      for (int i = 0; i < 4; i++) r_light[i] <= w_light_d[i];
    end
  end

  assign ps       = r_ps;
  assign count    = r_count;
  assign grant    = r_grant;
  assign Light_M1 = r_light[0];
  assign Light_M2 = r_light[1];
  assign Light_M3 = r_light[2];
  assign Light_M4 = r_light[3];

endmodule

// File: tb/tb_tl_phase_sched.sv
// Bench for tl_phase_sched: per-cycle comparison against a phase/timer model
// plus directed literal checks of the scheduling scenarios.
module tb_tl_phase_sched;

  localparam int GM = 4;
  localparam int GX = 10;
  localparam int YT = 3;
  localparam int AT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, emg;
  logic [2:0] Light_M1, Light_M2, Light_M3, Light_M4;
  logic [3:0] count;
  logic [2:0] ps;
  logic [1:0] grant;

  int n_vec = 0;
  int n_bad = 0;

  tl_phase_sched #(
    .GREEN_MIN(GM),
    .GREEN_MAX(GX),
    .YELLOW_T (YT),
    .ALLRED_T (AT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .emg     (emg),
    .Light_M1(Light_M1),
    .Light_M2(Light_M2),
    .Light_M3(Light_M3),
    .Light_M4(Light_M4),
    .count   (count),
    .ps      (ps),
    .grant   (grant)
  );

  always #5 clk = ~clk;

  // Model: phase code (0 idle,1 green,2 yellow,3 all-red,4 emergency),
  // cycles spent in the phase (unbounded) and served approach.
  int m_ph, m_t, m_g;
  bit m_valid = 1'b0;

  function automatic void arbitrate(input logic [3:0] r, input logic [3:0] e,
                                    output int ph, output int g);
    ph = 0;
    g  = m_g;
    if (e != 4'd0) begin
      ph = 4;
      for (int i = 0; i < 4; i++) if (e[i]) begin g = i; break; end
    end else if (r != 4'd0) begin
      ph = 1;
      for (int k = 1; k <= 4; k++) if (r[(m_g + k) % 4]) begin g = (m_g + k) % 4; break; end
    end
  endfunction

  always @(posedge clk) begin
    int nph, ng;
    logic [3:0] others;
    if (rst !== 1'b1) begin
      m_ph = 0; m_t = 0; m_g = 3; m_valid = 1'b1;
    end else if (m_valid) begin
      nph = m_ph;
      ng  = m_g;
      others = ~(4'b0001 << m_g);
      case (m_ph)
        0: arbitrate(req, emg, nph, ng);
        1: begin
          if (emg[m_g]) nph = 4;
          else if ((emg & others) != 0) nph = 2;
          else if (m_t + 1 >= GM && (req & others) != 0) nph = 2;
        end
        2: if (m_t + 1 == YT) nph = 3;
        3: if (m_t + 1 == AT) arbitrate(req, emg, nph, ng);
        default: if (!emg[m_g]) nph = 2;
      endcase
      m_t  = (nph != m_ph) ? 0 : m_t + 1;
      m_ph = nph;
      m_g  = ng;
    end
  end

  function automatic logic [2:0] exp_lamp(input int i);
    if (i == m_g && (m_ph == 1 || m_ph == 4)) return 3'b001;
    if (i == m_g && m_ph == 2) return 3'b010;
    return 3'b100;
  endfunction

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [3:0] ecnt;
    if (m_valid) begin
      if (m_ph == 1) ecnt = 4'((m_t < GX - 1) ? m_t : GX - 1);
      else           ecnt = 4'((m_t < 15) ? m_t : 15);
      n_vec++;
      if (ps !== 3'(m_ph) || count !== ecnt || grant !== 2'(m_g) ||
          Light_M1 !== exp_lamp(0) || Light_M2 !== exp_lamp(1) ||
          Light_M3 !== exp_lamp(2) || Light_M4 !== exp_lamp(3)) begin
        n_bad++;
        $display("FAIL model t=%0t: got ps=%0d cnt=%0d g=%0d L=%b_%b_%b_%b want ps=%0d cnt=%0d g=%0d L=%b_%b_%b_%b",
                 $time, ps, count, grant, Light_M1, Light_M2, Light_M3, Light_M4,
                 m_ph, ecnt, m_g, exp_lamp(0), exp_lamp(1), exp_lamp(2), exp_lamp(3));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string name);
    chk(name, {ps, count, grant}, {3'd0, 4'd0, 2'd3});
    chk(name, {Light_M1, Light_M2, Light_M3, Light_M4}, {4{3'b100}});
  endtask

  initial begin
    rst = 1'b0; req = 4'd0; emg = 4'd0;
    tick(2);
    chk_reset("reset_initial");

    // Idle with no requests.
    rst = 1'b1;
    tick(3);
    chk("idle", {ps, count, grant}, {3'd0, 4'd3, 2'd3});

    // Single request rests on green.
    req = 4'b0100;
    tick(1);
    chk("single_green", {ps, grant, Light_M3}, {3'd1, 2'd2, 3'b001});
    tick(25);
    chk("single_rest", {ps, count, Light_M3}, {3'd1, 4'd9, 3'b001});

    // Reset from green.
    rst = 1'b0; req = 4'b0011;
    tick(2);
    chk_reset("reset_from_green");

    // Round-robin between M1 and M2.
    rst = 1'b1;
    tick(1);
    chk("rr_m1_green", {ps, grant, Light_M1}, {3'd1, 2'd0, 3'b001});
    tick(4);
    chk("rr_m1_yellow", {ps, Light_M1}, {3'd2, 3'b010});
    tick(3);
    chk("rr_allred", {ps, Light_M1, Light_M2}, {3'd3, 3'b100, 3'b100});
    tick(2);
    chk("rr_m2_green", {ps, grant, Light_M2}, {3'd1, 2'd1, 3'b001});
    tick(9);
    chk("rr_m1_again", {ps, grant, Light_M1}, {3'd1, 2'd0, 3'b001});

    // Wrap from M4 back to M1.
    req = 4'b1001;
    for (int i = 0; i < 40 && !(ps == 3'd3 && grant == 2'd3); i++) tick(1);
    chk("wrap_reach", {ps, grant}, {3'd3, 2'd3});
    for (int i = 0; i < 5 && ps == 3'd3; i++) tick(1);
    chk("wrap_m1", {ps, grant, Light_M1}, {3'd1, 2'd0, 3'b001});

    // Preemption by M4 while M1 is green at count 1.
    rst = 1'b0; req = 4'b0001;
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("pre_m1_cnt1", {ps, count, grant}, {3'd1, 4'd1, 2'd0});
    emg = 4'b1000;
    tick(1);
    chk("pre_yellow", {ps, grant, Light_M1}, {3'd2, 2'd0, 3'b010});
    tick(3);
    chk("pre_allred", {ps, Light_M1}, {3'd3, 3'b100});
    tick(2);
    chk("pre_emg", {ps, grant, Light_M4}, {3'd4, 2'd3, 3'b001});
    tick(20);
    chk("pre_emg_hold", {ps, count, Light_M4}, {3'd4, 4'd15, 3'b001});
    emg = 4'd0;
    tick(1);
    chk("pre_release", {ps, Light_M4}, {3'd2, 3'b010});
    tick(5);
    chk("pre_m1_back", {ps, grant, Light_M1}, {3'd1, 2'd0, 3'b001});

    // Emergency on the approach already green: direct transfer.
    emg = 4'b0001;
    tick(1);
    chk("emg_same", {ps, grant, Light_M1}, {3'd4, 2'd0, 3'b001});

    // Mid-yellow reset, then immediate re-grant.
    emg = 4'd0;
    tick(2);
    chk("mid_yellow", {ps, count, Light_M1}, {3'd2, 4'd1, 3'b010});
    rst = 1'b0; req = 4'b0010;
    tick(1);
    chk_reset("reset_mid_yellow");
    rst = 1'b1;
    tick(1);
    chk("regrant", {ps, grant, Light_M2}, {3'd1, 2'd1, 3'b001});

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
